// File: rtl/cascade_sequencer.sv
// Cascade feature sequencer: walks the per-stage feature counts, issues one
// request per feature, and stops early on the first failing stage verdict.
module cascade_sequencer #(
  parameter int NUM_STAGES = 22,
  parameter int CNT_W      = 8,
  parameter int IDX_W      = 12,
  parameter int STG_W      = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  output logic             feat_valid,
  input  logic             feat_ready,
  output logic [IDX_W-1:0] feat_idx,
  output logic [STG_W-1:0] stage_idx,
  output logic [CNT_W-1:0] feat_in_stage,
  output logic             last_in_stage,
  input  logic             res_valid,
  input  logic             res_pass,
  input  logic             cfg_we,
  input  logic [STG_W-1:0] cfg_stage,
  input  logic [CNT_W-1:0] cfg_count,
  output logic             busy,
  output logic             done,
  output logic             accept
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

  localparam int DEF_N = 22;
  // Stage 0 sits in the least significant byte.
  localparam logic [DEF_N*8-1:0] DEFAULT_PACKED = {
    8'd213, 8'd211, 8'd182, 8'd177, 8'd160, 8'd140, 8'd137, 8'd135,
    8'd102, 8'd111, 8'd103, 8'd80,  8'd71,  8'd56,  8'd51,  8'd50,
    8'd44,  8'd33,  8'd39,  8'd21,  8'd16,  8'd3
  };

  function automatic int default_count(input int i);
    if (i < DEF_N) return int'(DEFAULT_PACKED[i*8 +: 8]);
    return 0;
  endfunction

  state_t           state_reg, state_next;
  logic [STG_W-1:0] stage_reg, stage_next;
  logic [CNT_W-1:0] fis_reg, fis_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             accept_reg, accept_next;
  logic [CNT_W-1:0] count_reg [NUM_STAGES];
  logic [CNT_W-1:0] cur_count;
  logic             cfg_ok;
  logic             last_feat;
  logic             final_stage;

  // Table edits are only legal while no evaluation is walking it.
  assign cfg_ok = cfg_we && (state_reg == IDLE) && (32'(cfg_stage) < NUM_STAGES);

  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_count
      localparam logic [CNT_W-1:0] RESET_VAL = CNT_W'(default_count(gi));
      always_ff @(posedge Clk) begin
        if (Reset)
          count_reg[gi] <= RESET_VAL;
        else if (cfg_ok && (cfg_stage == STG_W'(gi)))
          count_reg[gi] <= cfg_count;
      end
    end
  endgenerate

  assign cur_count   = count_reg[stage_reg];
  assign last_feat   = (fis_reg == cur_count - CNT_W'(1));
  assign final_stage = (stage_reg == STG_W'(NUM_STAGES - 1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg  <= IDLE;
      stage_reg  <= '0;
      fis_reg    <= '0;
      idx_reg    <= '0;
      accept_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      stage_reg  <= stage_next;
      fis_reg    <= fis_next;
      idx_reg    <= idx_next;
      accept_reg <= accept_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    stage_next  = stage_reg;
    fis_next    = fis_reg;
    idx_next    = idx_reg;
    accept_next = accept_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next  = ISSUE;
          stage_next  = '0;
          fis_next    = '0;
          idx_next    = '0;
          accept_next = 1'b0;
        end
      end
      ISSUE: begin
        if (cur_count == '0) begin
          // Empty stage passes trivially without a verdict round-trip.
          if (final_stage) begin
            state_next  = FINISH;
            accept_next = 1'b1;
          end else begin
            stage_next = stage_reg + STG_W'(1);
            fis_next   = '0;
          end
        end else if (feat_ready) begin
          idx_next = idx_reg + IDX_W'(1);
          fis_next = fis_reg + CNT_W'(1);
          if (last_feat) state_next = WAIT;
        end
      end
      WAIT: begin
        if (res_valid) begin
          if (!res_pass) begin
            state_next  = FINISH;
            accept_next = 1'b0;
          end else if (final_stage) begin
            state_next  = FINISH;
            accept_next = 1'b1;
          end else begin
            state_next = ISSUE;
            stage_next = stage_reg + STG_W'(1);
            fis_next   = '0;
          end
        end
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign feat_valid    = (state_reg == ISSUE) && (cur_count != '0);
  assign last_in_stage = feat_valid && last_feat;
  assign feat_idx      = idx_reg;
  assign stage_idx     = stage_reg;
  assign feat_in_stage = fis_reg;
  assign busy          = (state_reg != IDLE);
  assign done          = (state_reg == FINISH);
  assign accept        = accept_reg;

endmodule

// File: tb/tb_cascade_sequencer.sv
// Directed-sequence bench for cascade_sequencer with randomized handshakes,
// checked against a stage-list model of the expected feature transfers.
module tb_cascade_sequencer;
  localparam int NS = 22;
  localparam int CW = 8;
  localparam int IW = 12;
  localparam int SW = 5;

  logic          Clk = 1'b0;
  logic          Reset, start, feat_ready, res_valid, res_pass, cfg_we;
  logic [SW-1:0] cfg_stage;
  logic [CW-1:0] cfg_count;
  logic          feat_valid, last_in_stage, busy, done, accept;
  logic [IW-1:0] feat_idx;
  logic [SW-1:0] stage_idx;
  logic [CW-1:0] feat_in_stage;

  cascade_sequencer #(.NUM_STAGES(NS), .CNT_W(CW), .IDX_W(IW), .STG_W(SW)) dut (
    .Clk(Clk), .Reset(Reset), .start(start),
    .feat_valid(feat_valid), .feat_ready(feat_ready), .feat_idx(feat_idx),
    .stage_idx(stage_idx), .feat_in_stage(feat_in_stage), .last_in_stage(last_in_stage),
    .res_valid(res_valid), .res_pass(res_pass),
    .cfg_we(cfg_we), .cfg_stage(cfg_stage), .cfg_count(cfg_count),
    .busy(busy), .done(done), .accept(accept)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;
  int model_cnt [NS];

  typedef struct {
    int idx;
    int stg;
    int fis;
    bit last;
  } xfer_t;
  xfer_t exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_defaults();
    model_cnt = '{3, 16, 21, 39, 33, 44, 50, 51, 56, 71, 80, 103, 111, 102,
                  135, 137, 140, 160, 177, 182, 211, 213};
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(feat_valid), 0);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_acc"},   32'(accept), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_stage"}, 32'(stage_idx), 0);
    check({tag, "_fis"},   32'(feat_in_stage), 0);
    check({tag, "_idx"},   32'(feat_idx), 0);
  endtask

  // Reset with start held high at the same edge: reset must win.
  task automatic do_reset(input string tag);
    @(negedge Clk);
    Reset = 1'b1; start = 1'b1; feat_ready = 1'b0; res_valid = 1'b0; res_pass = 1'b0; cfg_we = 1'b0;
    @(negedge Clk);
    check_all_zero(tag);
    Reset = 1'b0; start = 1'b0;
    @(negedge Clk);
    check({tag, "_still_idle"}, 32'(busy), 0);
    load_defaults();
    $display("[TB] reset %s", tag);
  endtask

  task automatic cfg_write(input int s, input int v);
    @(negedge Clk);
    cfg_we = 1'b1; cfg_stage = SW'(s); cfg_count = CW'(v);
    @(negedge Clk);
    cfg_we = 1'b0;
    if (s < NS) model_cnt[s] = v;
    $display("[TB] cfg stage %0d <= %0d", s, v);
  endtask

  // Expected transfer list: every feature of every stage up to and including the failing one.
  task automatic build_expect(input int fail_stage);
    int running = 0;
    exp_q.delete();
    for (int s = 0; s < NS; s++) begin
      for (int k = 0; k < model_cnt[s]; k++) begin
        exp_q.push_back('{running % (1 << IW), s, k, (k == model_cnt[s] - 1)});
        running++;
      end
      if (s == fail_stage) break;
    end
  endtask

  task automatic run_eval(input string tag, input int fail_stage, input bit rnd_ready,
                          input bit noise, input int abort_stage);
    int     cycles = 0, xfers = 0, n_exp, delay = 0, verdict_stage = -1, lim;
    bit     waiting = 0, finished = 0, aborted = 0, prev_stall = 0, exp_acc;
    logic [IW-1:0] p_idx;
    logic [SW-1:0] p_stg;
    logic [CW-1:0] p_fis;
    logic          p_last;
    xfer_t  e;
    build_expect(fail_stage);
    n_exp   = exp_q.size();
    exp_acc = (fail_stage < 0);
    lim     = (fail_stage < 0) ? NS - 1 : fail_stage;
    @(negedge Clk);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    while (!finished && cycles < 12000) begin
      res_valid = 1'b0; res_pass = 1'b0; cfg_we = 1'b0;
      if (waiting && verdict_stage == abort_stage) begin
        Reset = 1'b1; start = 1'b1;
        @(negedge Clk);
        check_all_zero({tag, "_abort"});
        Reset = 1'b0; start = 1'b0;
        @(negedge Clk);
        check({tag, "_abort_idle"}, 32'(busy), 0);
        load_defaults();
        aborted = 1;
        break;
      end
      if (waiting) begin
        if (delay == 0) begin
          res_valid = 1'b1;
          res_pass  = (verdict_stage != fail_stage);
          waiting   = 0;
        end else delay--;
      end else if (noise && $urandom_range(0, 3) == 0) begin
        res_valid = 1'b1;
        res_pass  = 1'($urandom);
      end
      if (noise && busy && $urandom_range(0, 3) == 0) begin
        cfg_we = 1'b1; cfg_stage = SW'($urandom_range(0, NS - 1)); cfg_count = CW'($urandom);
      end
      feat_ready = rnd_ready ? 1'($urandom) : 1'b1;
      if (cycles == 0) check({tag, "_acc_clr"}, 32'(accept), 0);
      check({tag, "_stage_bound"}, 32'(32'(stage_idx) <= 32'(lim)), 1);
      if (prev_stall) begin
        check({tag, "_hold_valid"}, 32'(feat_valid), 1);
        check({tag, "_hold_idx"},   32'(feat_idx), 32'(p_idx));
        check({tag, "_hold_stg"},   32'(stage_idx), 32'(p_stg));
        check({tag, "_hold_fis"},   32'(feat_in_stage), 32'(p_fis));
        check({tag, "_hold_last"},  32'(last_in_stage), 32'(p_last));
      end
      if (feat_valid && feat_ready) begin
        xfers++;
        if (exp_q.size() == 0) begin
          check({tag, "_extra_xfer"}, 32'(feat_idx), 32'hFFFF_FFFF);
          finished = 1;
        end else begin
          e = exp_q.pop_front();
          check({tag, "_idx"},  32'(feat_idx), 32'(e.idx));
          check({tag, "_stg"},  32'(stage_idx), 32'(e.stg));
          check({tag, "_fis"},  32'(feat_in_stage), 32'(e.fis));
          check({tag, "_last"}, 32'(last_in_stage), 32'(e.last));
          if (e.last) begin
            waiting = 1; delay = $urandom_range(0, 3); verdict_stage = e.stg;
          end
        end
      end
      prev_stall = feat_valid && !feat_ready;
      p_idx = feat_idx; p_stg = stage_idx; p_fis = feat_in_stage; p_last = last_in_stage;
      if (done) begin
        check({tag, "_accept"},   32'(accept), 32'(exp_acc));
        check({tag, "_done_busy"}, 32'(busy), 1);
        check({tag, "_xfers"},    32'(xfers), 32'(n_exp));
        finished = 1;
      end
      @(negedge Clk);
      cycles++;
    end
    res_valid = 1'b0; cfg_we = 1'b0; feat_ready = 1'b0;
    if (!aborted) begin
      check({tag, "_timeout"}, 32'(finished), 1);
      check({tag, "_done_pulse"}, 32'(done), 0);
      check({tag, "_idle_busy"}, 32'(busy), 0);
      repeat (3) @(negedge Clk);
      check({tag, "_acc_hold"}, 32'(accept), 32'(exp_acc));
    end
    $display("[TB] run %s: fail_stage=%0d transfers=%0d expected=%0d cycles=%0d aborted=%0d",
             tag, fail_stage, xfers, n_exp, cycles, aborted);
  endtask

  initial begin
    Reset = 1'b0; start = 1'b0; feat_ready = 1'b0; res_valid = 1'b0; res_pass = 1'b0;
    cfg_we = 1'b0; cfg_stage = '0; cfg_count = '0;
    load_defaults();
    do_reset("init");

    run_eval("all_pass", -1, 1'b0, 1'b0, -1);
    run_eval("fail_s1", 1, 1'b0, 1'b0, -1);

    cfg_write(0, 5);
    cfg_write(1, 0);
    cfg_write(22, 1);
    run_eval("cfg_fail_s2", 2, 1'b0, 1'b0, -1);

    cfg_write(3, 0);
    cfg_write(4, 0);
    cfg_write(5, 0);
    run_eval("zero_stages", 6, 1'b1, 1'b1, -1);

    do_reset("restore");
    run_eval("stall_all_pass", -1, 1'b1, 1'b1, -1);

    run_eval("abort_s7", -1, 1'b1, 1'b0, 7);
    run_eval("after_abort", 3, 1'b1, 1'b1, -1);
    run_eval("rand_fail", int'($urandom_range(0, NS - 1)), 1'b1, 1'b1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cascade_sequencer.md
CASCADE_SEQUENCER -- requirements
Module: cascade_sequencer

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 22, number of cascade stages.
REQ-002 SHALL have parameter CNT_W, default 8, width of a per-stage feature count.
REQ-003 SHALL have parameter IDX_W, default 12, width of the global feature index.
REQ-004 SHALL have parameter STG_W, default 5, width of the stage index.
REQ-005 SHALL have one clock and a synchronous, active-high reset: Clk input 1 (all state on rising edge); Reset input 1 (sync, active-high).
REQ-006 SHALL have port start, input, 1, pulse that begins one window evaluation.
REQ-007 SHALL have port feat_valid, output, 1, feature request valid.
REQ-008 SHALL have port feat_ready, input, 1, evaluator accepts the request.
REQ-009 SHALL have port feat_idx, output, IDX_W, global feature index.
REQ-010 SHALL have port stage_idx, output, STG_W, current stage.
REQ-011 SHALL have port feat_in_stage, output, CNT_W, feature offset within the stage.
REQ-012 SHALL have port last_in_stage, output, 1, marks the final feature of the stage.
REQ-013 SHALL have port res_valid, input, 1, evaluator stage verdict valid.
REQ-014 SHALL have port res_pass, input, 1, stage sum at or above threshold.
REQ-015 SHALL have ports cfg_we (input, 1), cfg_stage (input, STG_W) and cfg_count (input, CNT_W), the count-table write port.
REQ-016 SHALL have outputs busy (1), done (1, one-cycle pulse) and accept (1, valid with done).

Function
REQ-017 SHALL hold a NUM_STAGES x CNT_W count table; reset contents for default parameters: 3,16,21,39,33,44,50,51,56,71,80,103,111,102,135,137,140,160,177,182,211,213.
REQ-018 SHALL write cfg_count into entry cfg_stage on cfg_we only in IDLE; writes while busy, or with cfg_stage >= NUM_STAGES, are ignored.
REQ-019 SHALL implement states IDLE, ISSUE, WAIT, FINISH.
REQ-020 IDLE: start=1 -> ISSUE next cycle; stage_idx=0, feat_in_stage=0, feat_idx=0; start ignored in all other states.
REQ-021 ISSUE: feat_valid=1; outputs held stable while feat_ready=0.
REQ-022 ISSUE: on a transfer (feat_valid&feat_ready), feat_idx+1 and feat_in_stage+1; on the last_in_stage transfer, go to WAIT.
REQ-023 last_in_stage SHALL equal (feat_in_stage == count[stage_idx]-1) while feat_valid=1.
REQ-024 A stage with count 0 SHALL issue no features; it is treated as passed and the sequencer advances to the next stage without entering WAIT.
REQ-025 WAIT: res_valid is sampled only in WAIT and ignored elsewhere.
REQ-026 WAIT, pass, not the final stage: stage_idx+1, feat_in_stage=0, feat_idx continues the running sum; ISSUE on the next cycle.
REQ-027 WAIT, pass on stage NUM_STAGES-1: FINISH with accept=1.
REQ-028 WAIT, fail: FINISH with accept=0; remaining stages are skipped.
REQ-029 FINISH: done=1 for exactly one cycle with accept valid, then IDLE; accept holds until the next start.
REQ-030 busy SHALL be 1 in ISSUE, WAIT and FINISH.
REQ-031 Each stage SHALL add at most 1 cycle beyond its transfers plus the result wait; zero-count stages SHALL cost at most 1 cycle each.
REQ-032 feat_idx SHALL wrap modulo 2^IDX_W with no error flag; sizing IDX_W is the integrator's duty.

Reset
REQ-033 Reset=1 SHALL force IDLE in any state, including mid-operation, and clear feat_valid, done, accept, busy, stage_idx, feat_in_stage and feat_idx.
REQ-034 Reset SHALL restore the count table to its REQ-017 defaults.
REQ-035 When Reset and start are both asserted, Reset SHALL win.

Verification
REQ-036 Defaults, feat_ready=1, every stage passes -> 2135 transfers, feat_idx 0..2134 with no gaps, then done=1 and accept=1.
REQ-037 Stage 1 fails -> exactly 19 transfers (3+16), stage_idx never reaches 2, done=1 and accept=0.
REQ-038 Write cfg stage0=5 and stage1=0, fail at stage 2 -> 5 stage-0 features, no stage-1 issue, stage 2 starts at feat_idx=5.
REQ-039 Randomly toggle feat_ready -> outputs stable while stalled; the transfer sequence matches the no-stall run.
REQ-040 Reset during WAIT of stage 7 -> next cycle IDLE, all outputs 0; a fresh start runs from feat_idx=0.
REQ-041 cfg_we while busy, and res_valid while in ISSUE -> both ignored; the table and the sequence are unchanged.
